// File: rtl/rv32im_pkg.sv
// Shared RV32M definitions: funct3 operation codes, MDU states and
// the architectural constants for the special divide results.
package rv32im_pkg;

    localparam int XLEN = 32;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } mdu_op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CALC,
        ST_FIXUP,
        ST_SPECIAL,
        ST_DONE
    } mdu_state_e;

    // Quotient of a divide by zero, and the most negative integer.
    localparam logic [XLEN-1:0] DIV_ZERO_Q = '1;
    localparam logic [XLEN-1:0] INT_MIN    = {1'b1, {(XLEN-1){1'b0}}};

endpackage

// File: rtl/mdu_step.sv
// One iteration of the MDU datapath. The accumulator holds
// {upper, lower} halves:
//   multiply: {partial product, remaining multiplier bits}; shift-add.
//   divide:   {partial remainder, remaining dividend / quotient bits};
//             restoring trial subtract.
module mdu_step #(
    parameter int data_width = 32
) (
    input  logic                      is_div,
    input  logic [2*data_width-1:0]   acc,
    input  logic [data_width-1:0]     opnd,
    output logic [2*data_width-1:0]   acc_next
);

    logic [data_width:0]   mul_sum;
    logic [data_width:0]   div_shift;
    logic [data_width-1:0] div_diff;
    logic                  div_ge;

    // Compute both candidate steps and select by operation class.
    always_comb begin
        mul_sum   = {1'b0, acc[2*data_width-1:data_width]}
                  + {1'b0, (acc[0] ? opnd : {data_width{1'b0}})};
        div_shift = {acc[2*data_width-1:data_width], acc[data_width-1]};
        div_ge    = (div_shift >= {1'b0, opnd});
        // When the trial subtract succeeds the true difference is below
        // opnd, so the low data_width bits are exact.
        div_diff  = div_shift[data_width-1:0] - opnd;
        if (is_div) begin
            acc_next = {(div_ge ? div_diff : div_shift[data_width-1:0]),
                        acc[data_width-2:0], div_ge};
        end else begin
            acc_next = {mul_sum, acc[data_width-1:1]};
        end
    end

endmodule

// File: rtl/mdu_iterative.sv
// Iterative RV32M multiply/divide unit. Accepts one operation in IDLE,
// iterates data_width cycles (or takes the one-cycle special path for
// divide-by-zero / signed overflow), and holds the result until taken.
module mdu_iterative
    import rv32im_pkg::*;
#(
    parameter int data_width = 32,
    parameter int TAG_W      = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2:0]            op,
    input  logic [data_width-1:0] operand_A,
    input  logic [data_width-1:0] operand_B,
    input  logic [TAG_W-1:0]      tag_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [data_width-1:0] result,
    output logic [TAG_W-1:0]      tag_out,
    output logic                  busy
);

    localparam int CNT_W = $clog2(data_width);
    localparam logic [CNT_W-1:0] last_count = CNT_W'(data_width - 1);
    // Package constants are XLEN wide; replicate their bit patterns to data_width.
    localparam logic [data_width-1:0] div_zero_q = {data_width{DIV_ZERO_Q[0]}};
    localparam logic [data_width-1:0] int_min    = {INT_MIN[XLEN-1], {(data_width-1){INT_MIN[0]}}};

    mdu_state_e              state, state_next;
    mdu_op_e                 op_in, op_q;
    logic [TAG_W-1:0]        tag_q;
    logic [2*data_width-1:0] acc, acc_step;
    logic [data_width-1:0]   opnd_q, result_q;
    logic [CNT_W-1:0]        count;
    logic                    neg_q, out_valid_q;

    logic                    accept, transfer, is_div_q;
    logic                    a_neg, b_neg, special_in, neg_in;
    logic [data_width-1:0]   a_mag, b_mag;
    logic [2*data_width-1:0] prod_fix;
    logic [data_width-1:0]   div_sel, fixup_res, special_res;

    assign in_ready  = (state == ST_IDLE);
    assign busy      = (state != ST_IDLE);
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign tag_out   = tag_q;
    assign accept    = in_valid && in_ready && !flush;
    assign transfer  = out_valid_q && out_ready;
    assign op_in     = mdu_op_e'(op);
    assign is_div_q  = (op_q inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU});

    // Decode a request: operand signedness, magnitudes, sign fix-up, special cases.
    always_comb begin
        // NOTE: every output of a combinational block is given a value on
        // every path, otherwise synthesis infers a latch.
        a_neg      = 1'b0;
        b_neg      = 1'b0;
        special_in = 1'b0;
        if (op_in inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM}) a_neg = operand_A[data_width-1];
        if (op_in inside {OP_MULH, OP_DIV, OP_REM})            b_neg = operand_B[data_width-1];
        a_mag  = a_neg ? -operand_A : operand_A;
        b_mag  = b_neg ? -operand_B : operand_B;
        neg_in = (op_in == OP_REM) ? a_neg : (a_neg ^ b_neg);
        if (op[2]) begin
            special_in = (operand_B == '0)
                      || (!op[0] && operand_A == int_min && operand_B == '1);
        end
    end

    // Sign correction and result selection for the FIXUP and SPECIAL states.
    always_comb begin
        prod_fix  = neg_q ? -acc : acc;
        div_sel   = (op_q inside {OP_REM, OP_REMU}) ? acc[2*data_width-1:data_width]
                                                    : acc[data_width-1:0];
        if (is_div_q) begin
            fixup_res = neg_q ? -div_sel : div_sel;
        end else if (op_q == OP_MUL) begin
            fixup_res = prod_fix[data_width-1:0];
        end else begin
            fixup_res = prod_fix[2*data_width-1:data_width];
        end
        // Special path keeps the raw dividend in acc and raw divisor in opnd_q.
        if (opnd_q == '0) begin
            special_res = (op_q inside {OP_REM, OP_REMU}) ? acc[data_width-1:0] : div_zero_q;
        end else begin
            special_res = (op_q == OP_REM) ? '0 : int_min;
        end
    end

    mdu_step #(.data_width(data_width)) u_step (
        .is_div   (is_div_q),
        .acc      (acc),
        .opnd     (opnd_q),
        .acc_next (acc_step)
    );

    // Next-state logic; flush overrides everything.
    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE:    if (accept) state_next = special_in ? ST_SPECIAL : ST_CALC;
            ST_CALC:    if (count == last_count) state_next = ST_FIXUP;
            ST_FIXUP:   state_next = ST_DONE;
            ST_SPECIAL: state_next = ST_DONE;
            ST_DONE:    if (transfer) state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
        if (flush) state_next = ST_IDLE;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of block ordering.
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_next;
    end

    // Datapath registers: capture on accept, iterate in CALC, resolve the result.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the datapath is reset along with the control so a reset
        // mid-operation can never expose a partial result.
        if (!rst_n) begin
            op_q     <= OP_MUL;
            tag_q    <= '0;
            acc      <= '0;
            opnd_q   <= '0;
            neg_q    <= 1'b0;
            count    <= '0;
            result_q <= '0;
        end else if (accept) begin
            op_q   <= op_in;
            tag_q  <= tag_in;
            neg_q  <= neg_in;
            count  <= '0;
            if (special_in) begin
                acc    <= {{data_width{1'b0}}, operand_A};
                opnd_q <= operand_B;
            end else if (op[2]) begin
                acc    <= {{data_width{1'b0}}, a_mag};
                opnd_q <= b_mag;
            end else begin
                acc    <= {{data_width{1'b0}}, b_mag};
                opnd_q <= a_mag;
            end
        end else if (state == ST_CALC) begin
            acc   <= acc_step;
            count <= count + 1'b1;
        end else if (state == ST_FIXUP) begin
            result_q <= fixup_res;
        end else if (state == ST_SPECIAL) begin
            result_q <= special_res;
        end
    end

    // out_valid is registered: raised one edge after DONE is entered, cleared on transfer or flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     out_valid_q <= 1'b0;
        else if (flush) out_valid_q <= 1'b0;
        else            out_valid_q <= (state == ST_DONE) && !transfer;
    end

endmodule

// File: tb/tb_mdu_iterative.sv
// Self-checking bench for mdu_iterative: directed RV32M cases, backpressure,
// flush and reset, then randomized operations against an arithmetic model.
module tb_mdu_iterative;
    import rv32im_pkg::*;

    localparam int DW = 32;
    localparam int TW = 5;
    localparam int NORMAL_LAT  = DW + 2;
    localparam int SPECIAL_LAT = 2;

    logic          clk = 1'b0;
    logic          rst_n, flush, in_valid, in_ready, out_valid, out_ready, busy;
    logic [2:0]    op;
    logic [DW-1:0] operand_A, operand_B, result;
    logic [TW-1:0] tag_in, tag_out;

    int checks   = 0;
    int failures = 0;

    logic          exp_pending = 1'b0;
    logic [DW-1:0] exp_result  = '0;
    logic [TW-1:0] exp_tag     = '0;

    always #5 clk = ~clk;

    mdu_iterative #(.data_width(DW), .TAG_W(TW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .operand_A (operand_A),
        .operand_B (operand_B),
        .tag_in    (tag_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .tag_out   (tag_out),
        .busy      (busy)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Reference model: full-width 64-bit arithmetic on sign/zero-extended operands.
    function automatic logic [DW-1:0] model(input logic [2:0] o, input logic [DW-1:0] a, input logic [DW-1:0] b);
        logic [63:0] sa, sb, ua, ub, p;
        sa = {{32{a[DW-1]}}, a};
        sb = {{32{b[DW-1]}}, b};
        ua = {32'b0, a};
        ub = {32'b0, b};
        case (o)
            3'd0: begin p = ua * ub; return p[31:0];  end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return $signed(a) / $signed(b);
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                return $signed(a) % $signed(b);
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // Compare process: whenever a result is presented it must match the model.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (exp_pending) begin
                check("model result", result, exp_result);
                check("model tag", tag_out, exp_tag);
            end else begin
                check("out_valid without request", out_valid, 1'b0);
            end
        end
    end

    // One full transaction, entered and left #1 after a rising edge.
    task automatic do_op(input logic [2:0] o, input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic [TW-1:0] tg, input int exp_lat, input bit use_lit,
                         input logic [DW-1:0] lit, input int hold);
        int n;
        logic [DW-1:0] r0;
        logic [TW-1:0] t0;
        check("in_ready before request", in_ready, 1'b1);
        out_ready = (hold == 0);
        op = o; operand_A = a; operand_B = b; tag_in = tg; in_valid = 1'b1;
        @(posedge clk);
        exp_result  = model(o, a, b);
        exp_tag     = tg;
        exp_pending = 1'b1;
        #1;
        in_valid = 1'b0;
        op = 3'($urandom); operand_A = $urandom; operand_B = $urandom; tag_in = TW'($urandom);
        n = 0;
        while (n < 100) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (n == 1) begin
                check("busy after accept", busy, 1'b1);
                check("in_ready after accept", in_ready, 1'b0);
            end
            if (out_valid) break;
        end
        if (!out_valid) begin
            check("out_valid timeout", out_valid, 1'b1);
            exp_pending = 1'b0;
            return;
        end
        check("latency", n, exp_lat);
        check("tag_out", tag_out, tg);
        if (use_lit) check("literal result", result, lit);
        r0 = result;
        t0 = tag_out;
        repeat (hold) begin
            @(negedge clk);
            check("held result", result, r0);
            check("held tag", tag_out, t0);
            check("held out_valid", out_valid, 1'b1);
            check("in_ready while held", in_ready, 1'b0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        exp_pending = 1'b0;
        check("out_valid after transfer", out_valid, 1'b0);
        check("in_ready after transfer", in_ready, 1'b1);
        check("busy after transfer", busy, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]    rop;
        logic [DW-1:0] ra, rb;
        logic          special, seen;

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        op = 3'd0; operand_A = '0; operand_B = '0; tag_in = '0;

        // Pin the model with hand-computed values.
        check("model MUL 7*-3", model(OP_MUL, 32'd7, 32'hFFFF_FFFD), 32'hFFFF_FFEB);
        check("model DIV -7/2", model(OP_DIV, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFD);
        check("model REM -7/2", model(OP_REM, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFF);
        check("model MULHSU -1*2", model(OP_MULHSU, 32'hFFFF_FFFF, 32'd2), 32'hFFFF_FFFF);

        #12;
        check("reset in_ready", in_ready, 1'b1);
        check("reset out_valid", out_valid, 1'b0);
        check("reset busy", busy, 1'b0);
        check("reset result", result, '0);
        check("reset tag_out", tag_out, '0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed arithmetic.
        do_op(OP_MUL,    32'd7,         32'hFFFF_FFFD, 5'd3,  NORMAL_LAT, 1, 32'hFFFF_FFEB, 0);
        do_op(OP_MULH,   32'h8000_0000, 32'h8000_0000, 5'd4,  NORMAL_LAT, 1, 32'h4000_0000, 0);
        do_op(OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5,  NORMAL_LAT, 1, 32'hFFFF_FFFE, 0);
        do_op(OP_MULHSU, 32'hFFFF_FFFF, 32'h0000_0002, 5'd6,  NORMAL_LAT, 1, 32'hFFFF_FFFF, 0);
        do_op(OP_DIV,    32'hFFFF_FFF9, 32'd2,         5'd7,  NORMAL_LAT, 1, 32'hFFFF_FFFD, 0);
        do_op(OP_REM,    32'hFFFF_FFF9, 32'd2,         5'd8,  NORMAL_LAT, 1, 32'hFFFF_FFFF, 0);
        do_op(OP_DIVU,   32'd100,       32'd7,         5'd9,  NORMAL_LAT, 1, 32'd14,        0);
        do_op(OP_REMU,   32'd100,       32'd7,         5'd10, NORMAL_LAT, 1, 32'd2,         0);

        // Special cases.
        do_op(OP_DIVU,   32'd1234,      32'd0,         5'd11, SPECIAL_LAT, 1, 32'hFFFF_FFFF, 0);
        do_op(OP_REMU,   32'd1234,      32'd0,         5'd12, SPECIAL_LAT, 1, 32'd1234,      0);
        do_op(OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 5'd13, SPECIAL_LAT, 1, 32'h8000_0000, 0);
        do_op(OP_REM,    32'h8000_0000, 32'hFFFF_FFFF, 5'd14, SPECIAL_LAT, 1, 32'd0,         0);
        do_op(OP_DIV,    32'd5,         32'd0,         5'd15, SPECIAL_LAT, 1, 32'hFFFF_FFFF, 0);
        do_op(OP_REM,    32'hFFFF_FFFB, 32'd0,         5'd16, SPECIAL_LAT, 1, 32'hFFFF_FFFB, 0);

        // Backpressure: result held for 5 cycles.
        do_op(OP_MULHU, 32'h1234_5678, 32'h9ABC_DEF0, 5'd17, NORMAL_LAT, 0, '0, 5);

        // Flush at CALC iteration 10 with a request presented in the flush cycle.
        check("in_ready before flush op", in_ready, 1'b1);
        op = OP_MUL; operand_A = 32'd11; operand_B = 32'd13; tag_in = 5'd18; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        flush = 1'b1; in_valid = 1'b1; op = OP_MUL; operand_A = 32'd9; operand_B = 32'd9; tag_in = 5'd19;
        @(posedge clk);
        #1;
        flush = 1'b0; in_valid = 1'b0;
        check("busy after flush", busy, 1'b0);
        check("in_ready after flush", in_ready, 1'b1);
        check("out_valid after flush", out_valid, 1'b0);
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check("out_valid never after flush", seen, 1'b0);
        @(posedge clk);
        #1;
        do_op(OP_MUL, 32'd3, 32'd5, 5'd20, NORMAL_LAT, 1, 32'd15, 0);

        // Flush in IDLE with a request: must not be accepted.
        flush = 1'b1; in_valid = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0; in_valid = 1'b0;
        check("idle flush request ignored", busy, 1'b0);

        // Flush discards a result pending in DONE.
        out_ready = 1'b0;
        op = OP_MULHU; operand_A = 32'hDEAD_BEEF; operand_B = 32'h0000_1000; tag_in = 5'd21; in_valid = 1'b1;
        @(posedge clk);
        exp_result = model(OP_MULHU, 32'hDEAD_BEEF, 32'h0000_1000);
        exp_tag = 5'd21; exp_pending = 1'b1;
        #1;
        in_valid = 1'b0;
        repeat (NORMAL_LAT) @(posedge clk);
        #1;
        check("out_valid before DONE flush", out_valid, 1'b1);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0; exp_pending = 1'b0; out_ready = 1'b1;
        check("out_valid after DONE flush", out_valid, 1'b0);
        check("in_ready after DONE flush", in_ready, 1'b1);

        // Asynchronous reset mid-CALC.
        op = OP_DIV; operand_A = 32'd1000; operand_B = 32'd3; tag_in = 5'd22; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async reset in_ready", in_ready, 1'b1);
        check("async reset out_valid", out_valid, 1'b0);
        check("async reset busy", busy, 1'b0);
        check("async reset result", result, '0);
        check("async reset tag_out", tag_out, '0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Randomized operations, biased towards the divide corner cases.
        for (int i = 0; i < 40; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = $urandom;
            rb  = $urandom;
            case ($urandom_range(0, 7))
                0: rb = '0;
                1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                2: rb = 32'($urandom_range(1, 15));
                default: ;
            endcase
            special = rop[2] && (rb == 0 || (!rop[0] && ra == 32'h8000_0000 && rb == 32'hFFFF_FFFF));
            do_op(rop, ra, rb, TW'($urandom), special ? SPECIAL_LAT : NORMAL_LAT, 0, '0,
                  int'($urandom_range(0, 2)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
